apb_req_master: RTL
===================

# apb_req_master

Single-channel APB requester that sits directly upstream of the APB slave. It turns a valid/ready transfer request into a compliant SETUP/ACCESS sequence on the slave-side signals (`addr`, `wr_data`, `wr`, `sel`, `enable`). It honours slave wait states via `ready` and returns read data and status on a one-cycle response strobe. A programmable timeout aborts transfers whose slave never asserts `ready`.

## Interface

**Parameters**
- `ADDR_W`, 32: address width
- `DATA_W`, 32: data width
- `TIMEOUT`, 16: maximum consecutive ACCESS cycles with `ready` low before abort; 0 disables the timeout

**Ports**
- `clk` in 1: single clock; all logic on posedge
- `rstn` in 1: reset, asynchronous assert, active-low
- `req_valid` in 1: request present
- `req_ready` out 1: request accepted at the posedge where `req_valid && req_ready`
- `req_wr` in 1: 1 = write, 0 = read
- `req_addr` in `ADDR_W`: transfer address
- `req_wdata` in `DATA_W`: write data (ignored on reads)
- `rsp_valid` out 1: one-cycle completion strobe
- `rsp_rdata` out `DATA_W`: read data; 0 for writes and aborts
- `rsp_err` out 1: 1 = timeout abort
- `addr` out `ADDR_W`: APB address
- `wr_data` out `DATA_W`: APB write data
- `wr` out 1: APB write enable
- `sel` out 1: APB select
- `enable` out 1: APB enable
- `ready` in 1: slave ready
- `out_data` in `DATA_W`: slave read data

## Operation

- FSM states: IDLE, SETUP, ACCESS.
- **IDLE:** `sel=0`, `enable=0`, `req_ready=1`. On accept, latch `req_wr`/`req_addr`/`req_wdata` into `wr`/`addr`/`wr_data`, then go to SETUP.
- **SETUP:** `sel=1`, `enable=0`, `req_ready=0`. Always goes to ACCESS next cycle.
- **ACCESS:** `sel=1`, `enable=1`. `addr`, `wr`, `wr_data` are held stable for the whole transfer.
- **ACCESS, `ready=1` at posedge:** the transfer completes.
  - For a read, capture `out_data` into `rsp_rdata`; for a write, set `rsp_rdata` to 0.
  - Set `rsp_err=0` and pulse `rsp_valid` for the next cycle.
- **Back-to-back:** in ACCESS, `req_ready = ready` (combinational path from `ready`).
  - If a new request is accepted at the completing edge, go straight to SETUP with the new latched values and keep `sel` high.
  - Otherwise return to IDLE.
- **Wait counter:** cleared on entry to ACCESS; increments on each ACCESS cycle with `ready=0`.
- **Timeout:** if `TIMEOUT>0` and the counter reaches `TIMEOUT` with `ready` still 0, abort.
  - Go to IDLE; `sel` and `enable` drop.
  - Pulse `rsp_valid` with `rsp_err=1` and `rsp_rdata=0`.
  - `req_ready` stays 0 at the abort edge.
- Counter width is `$clog2(TIMEOUT+1)`, minimum 1. It saturates and never wraps.
- In IDLE, `addr`/`wr_data`/`wr` keep their last values (no toggling); only `sel`/`enable` indicate activity.
- `rsp_rdata` and `rsp_err` hold their values until the next response.

## Timing

- **Reset:** while `rstn=0`, all outputs are 0 (`req_ready` included), FSM is in IDLE, counter is 0. Assertion takes effect immediately, with no clock needed.
- **After release:** the first rising edge sees IDLE, so `req_ready=1`.
- **Zero-wait latency:**
  - Accept edge E.
  - SETUP during cycle E+1.
  - ACCESS during E+2; completes at edge E+2.
  - `rsp_valid` high during cycle E+3.
- **Wait states:** each `ready=0` cycle in ACCESS adds exactly one cycle.
- **Throughput:** with `req_valid` held and `ready=1`, one transfer per 2 cycles; `sel` stays continuously high and `enable` alternates 0/1.
- **Response vs. next transfer:** `rsp_valid` is registered. It may coincide with the SETUP cycle of the next transfer.
- **Reset mid-transfer:** `sel`/`enable` go low asynchronously and no `rsp_valid` is issued for the in-flight transfer.
- **Simultaneous completion and timeout:** `ready=1` on the cycle the counter would reach `TIMEOUT` is a normal completion, not an error.

## Test plan

- **Reset:** hold `rstn=0` with random inputs. Expect all outputs 0. Release; at the first posedge `req_ready=1`, `sel=0`.
- **Single write, `ready` tied 1:** write 12 to addr 22.
  - SETUP cycle: `sel=1`, `enable=0`, `wr=1`, `addr=22`, `wr_data=12`.
  - Next cycle: `enable=1`.
  - Next cycle: `rsp_valid=1`, `rsp_err=0`, `rsp_rdata=0`.
- **Read with waits:** read addr 23 with `ready=0` for 3 ACCESS cycles, then 1, and `out_data=13`.
  - ACCESS lasts 4 cycles with `addr=23` stable.
  - Expect `rsp_rdata=13`, `rsp_err=0`.
- **Back-to-back writes:** writes 12..16 to addrs 22..26 with `req_valid` held.
  - All five complete in 10 cycles with `sel` never dropping.
  - Exactly 5 `rsp_valid` pulses.
- **Timeout, `TIMEOUT=4`:** read with `ready` stuck 0.
  - After 4 ACCESS cycles, `sel`/`enable` drop and `rsp_valid=1`, `rsp_err=1`, `rsp_rdata=0`.
  - A following read of addr 24 with `ready=1` completes normally.
- **Reset during ACCESS:** pulse `rstn=0` mid-transfer.
  - `sel`/`enable` go 0 before the next edge and no `rsp_valid` is issued.
  - A subsequent write of 15 to addr 25 completes normally.

Source files
------------

// File: rtl/apb_req_master.sv
// APB requester: turns a valid/ready request into a SETUP/ACCESS sequence,
// honours slave wait states and aborts a transfer whose slave never answers.
module apb_req_master #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr,
    output logic              sel,
    output logic              enable,
    input  logic              ready,
    input  logic [DATA_W-1:0] out_data
);

    localparam int unsigned CNT_W     = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned TO_LAST_I = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam bit TO_EN = (TIMEOUT != 0);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess} state_e;

    state_e            r_state;
    state_e            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_wr;
    logic              r_rsp_valid;
    logic [DATA_W-1:0] r_rsp_rdata;
    logic              r_rsp_err;

    logic w_req_ready;
    logic w_accept;
    logic w_done;
    logic w_abort;

    assign w_accept = req_valid && w_req_ready;
    assign w_done   = (r_state == StAccess) && ready;
    // The timeout fires on the edge where the counter would reach TIMEOUT;
    // a ready on that same edge wins and completes normally.
    assign w_abort  = TO_EN && (r_state == StAccess) && !ready && (r_cnt == TO_LAST);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle: begin
                if (w_accept) w_state_next = StSetup;
            end
            StSetup: begin
                w_state_next = StAccess;
            end
            StAccess: begin
                if (ready) begin
                    w_state_next = w_accept ? StSetup : StIdle;
                end else if (w_abort) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    // rstn gates req_ready so the requester reads as not-ready while held in reset.
    always_comb begin
        sel         = 1'b0;
        enable      = 1'b0;
        w_req_ready = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_req_ready = rstn;
            end
            StSetup: begin
                sel = 1'b1;
            end
            StAccess: begin
                sel         = 1'b1;
                enable      = 1'b1;
                w_req_ready = ready;
            end
            default: begin
                sel = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_wr    <= 1'b0;
        end else if (w_accept) begin
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_wr    <= req_wr;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (r_state == StSetup) begin
            r_cnt <= '0;
        end else if ((r_state == StAccess) && !ready && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
        end else begin
            r_rsp_valid <= w_done || w_abort;
            if (w_done) begin
                r_rsp_rdata <= r_wr ? '0 : out_data;
                r_rsp_err   <= 1'b0;
            end else if (w_abort) begin
                r_rsp_rdata <= '0;
                r_rsp_err   <= 1'b1;
            end
        end
    end

    assign req_ready = w_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign addr      = r_addr;
    assign wr_data   = r_wdata;
    assign wr        = r_wr;

endmodule
